// File: rtl/nd_2to1_merge_pkg.sv
// Shared definitions for the 2-to-1 message merge node: field size defaults,
// ON/OFF constants, channel declaration macros, output FSM state encodings
// and the round-robin grant helper.
// Optional feature macro used by the node: NS_MERGE_REDUN_CHK_EN.

`ifndef ND_2TO1_MERGE_PKG_SV
`define ND_2TO1_MERGE_PKG_SV

// Declares the four payload fields plus req/ack of a channel as local signals.
`define NS_CHAN_DECL(s_n, d_n, x_n, r_n, q_n, k_n, a, d, r) \
    logic [(a)-1:0] s_n; \
    logic [(a)-1:0] d_n; \
    logic [(d)-1:0] x_n; \
    logic [(r)-1:0] r_n; \
    logic           q_n; \
    logic           k_n;

package nd_2to1_merge_pkg;

    // Field size defaults
    localparam int NS_ADDRESS_SIZE = 8;
    localparam int NS_DATA_SIZE    = 16;
    localparam int NS_REDUN_SIZE   = 4;

    // Single-bit level constants
    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

    // Output handshake FSM states
    typedef enum logic [1:0] {
        OUT_IDLE  = 2'd0,
        OUT_WAIT  = 2'd1,
        OUT_DRAIN = 2'd2
    } out_state_t;

    // Round-robin pick between two eligible channels.
    // Only one eligible: it wins. Both eligible: the one not granted last wins.
    function automatic logic pick_grant(input logic elig0,
                                        input logic elig1,
                                        input logic last_grant);
        if (elig0 && elig1) begin
            return ~last_grant;
        end
        return elig1;
    endfunction

endpackage

`endif

// File: rtl/nd_2to1_merge_calc_redun.sv
// Redundancy code generator for a message: XOR-folds the concatenation
// {src, dst, dat} into RSZ bits (bit k of the result is the XOR of every
// message bit whose position modulo RSZ equals k, counting from the LSB).
// Purely combinational; used by the merge node only when
// NS_MERGE_REDUN_CHK_EN is defined.

module nd_2to1_merge_calc_redun #(
    parameter int ASZ = 8,
    parameter int DSZ = 16,
    parameter int RSZ = 4
) (
    input  logic [ASZ-1:0] src,
    input  logic [ASZ-1:0] dst,
    input  logic [DSZ-1:0] dat,
    output logic [RSZ-1:0] redun
);

    localparam int VW     = 2 * ASZ + DSZ;
    localparam int CHUNKS = (VW + RSZ - 1) / RSZ;

    logic [VW-1:0] vec;

    assign vec = {src, dst, dat};

    // Fold the message into RSZ-bit chunks and XOR them together
    always_comb begin
        redun = '0;
        for (int c = 0; c < CHUNKS; c++) begin
            for (int b = 0; b < RSZ; b++) begin
                if (c * RSZ + b < VW) begin
                    redun[b] = redun[b] ^ vec[c * RSZ + b];
                end
            end
        end
    end

endmodule

// File: rtl/nd_2to1_merge.sv
// nd_2to1_merge: two-input, one-output message merge node on 4-phase req/ack
// channels with round-robin arbitration and a single message buffer.
// Optional feature macro: NS_MERGE_REDUN_CHK_EN -- when defined, each
// captured message has its redundancy recomputed one cycle after capture and
// is dropped (with a sticky err) on mismatch; when undefined, err is 0.
//
// Handshake (every channel): the sender holds its fields stable and raises
// req; the receiver raises ack once it has taken the fields; the sender then
// drops req; the receiver drops ack on seeing req low. A new transfer starts
// only once both req and ack are low again.

module nd_2to1_merge
    import nd_2to1_merge_pkg::*;
#(
    parameter int ASZ = NS_ADDRESS_SIZE,
    parameter int DSZ = NS_DATA_SIZE,
    parameter int RSZ = NS_REDUN_SIZE
) (
    input  logic           clk,
    input  logic           reset,
    // input channel 0
    input  logic [ASZ-1:0] i0_src,
    input  logic [ASZ-1:0] i0_dst,
    input  logic [DSZ-1:0] i0_dat,
    input  logic [RSZ-1:0] i0_red,
    input  logic           i0_req,
    output logic           i0_ack,
    // input channel 1
    input  logic [ASZ-1:0] i1_src,
    input  logic [ASZ-1:0] i1_dst,
    input  logic [DSZ-1:0] i1_dat,
    input  logic [RSZ-1:0] i1_red,
    input  logic           i1_req,
    output logic           i1_ack,
    // output channel
    output logic [ASZ-1:0] o0_src,
    output logic [ASZ-1:0] o0_dst,
    output logic [DSZ-1:0] o0_dat,
    output logic [RSZ-1:0] o0_red,
    output logic           o0_req,
    input  logic           o0_ack,
    // sticky redundancy error
    output logic           err
);

    // The o0_* field registers are the message buffer itself.
    out_state_t out_state;
    logic       buf_full;
    logic       last_grant;
    logic       elig0;
    logic       elig1;
    logic       grant;
    logic       capture;
    logic       chk_hold;
    logic       red_bad;

    // A channel is eligible only after its previous ack has been released.
    assign elig0   = i0_req & ~i0_ack;
    assign elig1   = i1_req & ~i1_ack;
    // Capture only into a buffer that is empty before this edge.
    assign capture = ~buf_full & (elig0 | elig1);
    assign grant   = pick_grant(elig0, elig1, last_grant);

`ifdef NS_MERGE_REDUN_CHK_EN
    logic           chk_pending;
    logic [RSZ-1:0] calc_red;

    nd_2to1_merge_calc_redun #(
        .ASZ (ASZ),
        .DSZ (DSZ),
        .RSZ (RSZ)
    ) u_calc_redun (
        .src   (o0_src),
        .dst   (o0_dst),
        .dat   (o0_dat),
        .redun (calc_red)
    );

    // A freshly captured message is checked on the following edge.
    assign red_bad  = chk_pending & (calc_red != o0_red);
    assign chk_hold = chk_pending;

    // Check-pending flag and sticky error flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk_pending <= OFF;
            err         <= OFF;
        end else begin
            chk_pending <= capture;
            if (red_bad) begin
                err <= ON;
            end
        end
    end
`else
    assign red_bad  = OFF;
    assign chk_hold = OFF;
    assign err      = OFF;
`endif

    // Input side: ack release, grant and ack raise, round-robin memory
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i0_ack     <= OFF;
            i1_ack     <= OFF;
            last_grant <= ON;
        end else begin
            if (i0_ack && !i0_req) begin
                i0_ack <= OFF;
            end
            if (i1_ack && !i1_req) begin
                i1_ack <= OFF;
            end
            if (capture) begin
                last_grant <= grant;
                if (grant) begin
                    i1_ack <= ON;
                end else begin
                    i0_ack <= ON;
                end
            end
        end
    end

    // Buffer load and output handshake FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_full  <= OFF;
            o0_req    <= OFF;
            out_state <= OUT_IDLE;
            o0_src    <= '0;
            o0_dst    <= '0;
            o0_dat    <= '0;
            o0_red    <= '0;
        end else begin
            case (out_state)
                OUT_IDLE: begin
                    if (buf_full && !chk_hold && !o0_ack) begin
                        o0_req    <= ON;
                        out_state <= OUT_WAIT;
                    end
                end
                OUT_WAIT: begin
                    if (o0_ack) begin
                        o0_req    <= OFF;
                        buf_full  <= OFF;
                        out_state <= OUT_DRAIN;
                    end
                end
                OUT_DRAIN: begin
                    if (!o0_ack) begin
                        out_state <= OUT_IDLE;
                    end
                end
                default: begin
                    out_state <= OUT_IDLE;
                end
            endcase

            // A message failing its redundancy check is discarded unsent.
            if (red_bad) begin
                buf_full <= OFF;
            end

            // capture implies the buffer was empty, so it never collides
            // with the buffer being emptied above.
            if (capture) begin
                buf_full <= ON;
                if (grant) begin
                    o0_src <= i1_src;
                    o0_dst <= i1_dst;
                    o0_dat <= i1_dat;
                    o0_red <= i1_red;
                end else begin
                    o0_src <= i0_src;
                    o0_dst <= i0_dst;
                    o0_dat <= i0_dat;
                    o0_red <= i0_red;
                end
            end
        end
    end

endmodule

// File: tb/tb_nd_2to1_merge.sv
// Testbench for nd_2to1_merge: directed handshakes on two source channels,
// a configurable sink, per-channel expected queues checked on every output
// request, and literal checks on timing, arbitration order and reset.

module tb_nd_2to1_merge;
  import nd_2to1_merge_pkg::*;

  localparam int ASZ = NS_ADDRESS_SIZE;
  localparam int DSZ = NS_DATA_SIZE;
  localparam int RSZ = NS_REDUN_SIZE;
  localparam int MW  = 2 * ASZ + DSZ + RSZ;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [ASZ-1:0] i0_src, i0_dst, i1_src, i1_dst, o0_src, o0_dst;
  logic [DSZ-1:0] i0_dat, i1_dat, o0_dat;
  logic [RSZ-1:0] i0_red, i1_red, o0_red;
  logic i0_req, i0_ack, i1_req, i1_ack, o0_req, o0_ack, err;

  always #5 clk = ~clk;

  nd_2to1_merge #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) dut (
    .clk(clk), .reset(reset),
    .i0_src(i0_src), .i0_dst(i0_dst), .i0_dat(i0_dat), .i0_red(i0_red),
    .i0_req(i0_req), .i0_ack(i0_ack),
    .i1_src(i1_src), .i1_dst(i1_dst), .i1_dat(i1_dat), .i1_red(i1_red),
    .i1_req(i1_req), .i1_ack(i1_ack),
    .o0_src(o0_src), .o0_dst(o0_dst), .o0_dat(o0_dat), .o0_red(o0_red),
    .o0_req(o0_req), .o0_ack(o0_ack),
    .err(err)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [MW-1:0]  exp_q0[$];
  logic [MW-1:0]  exp_q1[$];
  logic [DSZ-1:0] log_dat[$];
  logic [ASZ-1:0] log_src[$];

  logic sink_en = 1'b1;
  logic sink_rand = 1'b0;
  int   sink_delay = 0;
  int   sink_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Redundancy: XOR fold of {src,dst,dat}, message bit i lands in red bit i%RSZ.
  function automatic logic [RSZ-1:0] red_of(input logic [ASZ-1:0] s, input logic [ASZ-1:0] d,
                                            input logic [DSZ-1:0] x);
    logic [2*ASZ+DSZ-1:0] v;
    logic [RSZ-1:0] r;
    v = {s, d, x};
    r = '0;
    for (int i = 0; i < 2 * ASZ + DSZ; i++) r[i % RSZ] = r[i % RSZ] ^ v[i];
    return r;
  endfunction

  // ---------------- sink ----------------
  initial begin
    o0_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        o0_ack = 1'b0;
        sink_cnt = 0;
      end else if (o0_ack) begin
        if (!o0_req) o0_ack = 1'b0;
      end else if (o0_req && sink_en) begin
        if (sink_cnt >= sink_delay) begin
          o0_ack = 1'b1;
          sink_cnt = 0;
          if (sink_rand) sink_delay = $urandom_range(0, 3);
        end else begin
          sink_cnt++;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  logic [MW-1:0] cmp_cur, cmp_exp, cmp_act;
  logic cmp_prev_req = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        cmp_prev_req = 1'b0;
      end else begin
        cmp_act = {o0_src, o0_dst, o0_dat, o0_red};
        if (o0_req && !cmp_prev_req) begin
          if (o0_src == 0 && exp_q0.size() > 0) begin
            cmp_exp = exp_q0.pop_front();
            check("out_msg_ch0", 64'(cmp_act), 64'(cmp_exp));
          end else if (o0_src == 1 && exp_q1.size() > 0) begin
            cmp_exp = exp_q1.pop_front();
            check("out_msg_ch1", 64'(cmp_act), 64'(cmp_exp));
          end else begin
            check("out_unexpected_req", 64'(o0_req), 64'(0));
          end
          cmp_cur = cmp_act;
          log_dat.push_back(o0_dat);
          log_src.push_back(o0_src);
        end else if (o0_req) begin
          check("out_stable", 64'(cmp_act), 64'(cmp_cur));
        end
`ifndef NS_MERGE_REDUN_CHK_EN
        check("err_zero", 64'(err), 64'(0));
`endif
        cmp_prev_req = o0_req;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic offer(input int ch, input logic [ASZ-1:0] dst, input logic [DSZ-1:0] dat,
                       input logic bad);
    logic [ASZ-1:0] src;
    logic [RSZ-1:0] red;
    src = ASZ'(ch);
    red = red_of(src, dst, dat) ^ RSZ'(bad);
    if (!bad) begin
      if (ch == 0) exp_q0.push_back({src, dst, dat, red});
      else exp_q1.push_back({src, dst, dat, red});
    end
    if (ch == 0) begin
      i0_src = src; i0_dst = dst; i0_dat = dat; i0_red = red; i0_req = 1'b1;
    end else begin
      i1_src = src; i1_dst = dst; i1_dat = dat; i1_red = red; i1_req = 1'b1;
    end
  endtask

  task automatic complete(input int ch);
    logic a;
    int k;
    a = 1'b0;
    for (k = 0; k < 400; k++) begin
      @(posedge clk);
      #1;
      a = (ch == 0) ? i0_ack : i1_ack;
      if (a) break;
    end
    if (k == 400) check("ack_rise_timeout", 64'(a), 64'(1));
    if (ch == 0) i0_req = 1'b0; else i1_req = 1'b0;
    for (k = 0; k < 400; k++) begin
      @(posedge clk);
      #1;
      a = (ch == 0) ? i0_ack : i1_ack;
      if (!a) break;
    end
    if (k == 400) check("ack_fall_timeout", 64'(a), 64'(0));
  endtask

  task automatic send(input int ch, input logic [ASZ-1:0] dst, input logic [DSZ-1:0] dat,
                      input logic bad);
    offer(ch, dst, dat, bad);
    complete(ch);
  endtask

  task automatic wait_idle(input string name);
    logic idle;
    idle = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      #1;
      idle = (exp_q0.size() == 0) && (exp_q1.size() == 0) && !o0_req && !o0_ack
             && !i0_ack && !i1_ack;
      if (idle) break;
    end
    check(name, 64'(idle), 64'(1));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i0_req = 1'b0;
    i1_req = 1'b0;
    sink_en = 1'b1;
    sink_rand = 1'b0;
    sink_delay = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    log_dat.delete();
    log_src.delete();
  endtask

  // ---------------- main sequence ----------------
  logic [DSZ-1:0] alt_exp[8] = '{16'd3, 16'd9, 16'd4, 16'd10, 16'd5, 16'd11, 16'd6, 16'd12};
  int n_src0;
  int wait_k;

  initial begin
    i0_src = '0; i0_dst = '0; i0_dat = '0; i0_red = '0; i0_req = 1'b0;
    i1_src = '0; i1_dst = '0; i1_dat = '0; i1_red = '0; i1_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    check("rst_i0_ack", 64'(i0_ack), 64'(0));
    check("rst_i1_ack", 64'(i1_ack), 64'(0));
    check("rst_o0_req", 64'(o0_req), 64'(0));
    check("rst_o0_fields", 64'({o0_src, o0_dst, o0_dat, o0_red}), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    reset = 1'b0;
    exp_q0.delete();
    exp_q1.delete();

    // single channel timing and contents
    @(posedge clk);
    #1;
    offer(0, 8'd1, 16'd5, 1'b0);
    @(posedge clk);
    #1;
    check("t1_i0_ack_after_1", 64'(i0_ack), 64'(1));
    check("t1_o0_req_low_after_1", 64'(o0_req), 64'(0));
`ifdef NS_MERGE_REDUN_CHK_EN
    @(posedge clk);
    #1;
    check("t1_o0_req_low_during_chk", 64'(o0_req), 64'(0));
`endif
    @(posedge clk);
    #1;
    check("t1_o0_req_high", 64'(o0_req), 64'(1));
    check("t1_o0_src", 64'(o0_src), 64'(0));
    check("t1_o0_dst", 64'(o0_dst), 64'(1));
    check("t1_o0_dat", 64'(o0_dat), 64'(5));
    complete(0);
    wait_idle("t1_idle");
    check("t1_count", 64'(log_dat.size()), 64'(1));

    // tie after reset, then strict alternation
    do_reset();
    fork
      begin
        for (int i = 0; i < 4; i++) send(0, 8'd2, DSZ'(3 + i), 1'b0);
      end
      begin
        for (int i = 0; i < 4; i++) send(1, 8'd2, DSZ'(9 + i), 1'b0);
      end
    join
    wait_idle("t2_idle");
    check("t2_count", 64'(log_dat.size()), 64'(8));
    if (log_dat.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check("t2_order_dat", 64'(log_dat[i]), 64'(alt_exp[i]));
        check("t2_order_src", 64'(log_src[i]), 64'(i % 2));
      end
    end

    // back-pressure
    do_reset();
    sink_en = 1'b0;
    send(1, 8'd2, 16'h0077, 1'b0);
    offer(1, 8'd3, 16'h0088, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("t3_i1_ack_held_low", 64'(i1_ack), 64'(0));
      check("t3_o0_req_held", 64'(o0_req), 64'(1));
      check("t3_o0_dat_held", 64'(o0_dat), 64'(16'h0077));
    end
    sink_en = 1'b1;
    complete(1);
    wait_idle("t3_idle");
    check("t3_count", 64'(log_dat.size()), 64'(2));
    if (log_dat.size() == 2) check("t3_second_dat", 64'(log_dat[1]), 64'(16'h0088));

    // stream ordering with a variable-latency sink
    do_reset();
    sink_rand = 1'b1;
    sink_delay = 1;
    fork
      begin
        for (int i = 0; i < 16; i++) send(0, 8'd4, DSZ'(i), 1'b0);
      end
      begin
        for (int i = 0; i < 16; i++) send(1, 8'd5, DSZ'(i), 1'b0);
      end
    join
    wait_idle("t4_idle");
    check("t4_count", 64'(log_dat.size()), 64'(32));
    n_src0 = 0;
    foreach (log_src[i]) if (log_src[i] == 0) n_src0++;
    check("t4_count_ch0", 64'(n_src0), 64'(16));
    sink_rand = 1'b0;
    sink_delay = 0;

    // reset in the middle of a handshake
    do_reset();
    sink_en = 1'b0;
    offer(0, 8'd4, 16'h0055, 1'b0);
    for (wait_k = 0; wait_k < 10; wait_k++) begin
      @(posedge clk);
      #1;
      if (o0_req) break;
    end
    check("t5_o0_req_before", 64'(o0_req), 64'(1));
    check("t5_i0_ack_before", 64'(i0_ack), 64'(1));
    #2;
    reset = 1'b1;
    i0_req = 1'b0;
    #1;
    check("t5_i0_ack_async", 64'(i0_ack), 64'(0));
    check("t5_i1_ack_async", 64'(i1_ack), 64'(0));
    check("t5_o0_req_async", 64'(o0_req), 64'(0));
    check("t5_o0_fields_async", 64'({o0_src, o0_dst, o0_dat, o0_red}), 64'(0));
    check("t5_err_async", 64'(err), 64'(0));
    do_reset();
    @(posedge clk);
    #1;
    send(0, 8'd6, 16'h0066, 1'b0);
    wait_idle("t5_idle");
    check("t5_count", 64'(log_dat.size()), 64'(1));
    if (log_dat.size() == 1) check("t5_fresh_dat", 64'(log_dat[0]), 64'(16'h0066));

`ifdef NS_MERGE_REDUN_CHK_EN
    // corrupted redundancy is dropped and flagged
    do_reset();
    send(0, 8'd7, 16'h1234, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    check("t6_err_set", 64'(err), 64'(1));
    check("t6_no_out", 64'(log_dat.size()), 64'(0));
    send(1, 8'd8, 16'h4321, 1'b0);
    wait_idle("t6_idle");
    check("t6_err_sticky", 64'(err), 64'(1));
    check("t6_count", 64'(log_dat.size()), 64'(1));
    if (log_dat.size() == 1) check("t6_valid_dat", 64'(log_dat[0]), 64'(16'h4321));
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
